hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Parametrised next-generation hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).
- Stall and forward decisions use decoded Tuse/Tnew fields and destination addresses, not raw instruction words.
- Adds a multiply/divide busy tracker and a saturating stall-cycle performance counter.
- Sits beside the datapath and drives PC/D-register enables, the E-register flush and every forwarding mux select.

Parameters:
AW, 5, register address width
TW, 2, width of Tuse/Tnew fields
MULT_LAT, 5, cycles HI/LO is busy after a mult/multu start
DIV_LAT, 10, cycles HI/LO is busy after a div/divu start
CW, 4, md busy counter width; must hold max(MULT_LAT, DIV_LAT)
SCW, 32, stall performance counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
rs_d  in  AW  D-stage source 1 address
rt_d  in  AW  D-stage source 2 address
tuse_rs_d  in  TW  cycles until rs_d is needed (max = not used)
tuse_rt_d  in  TW  cycles until rt_d is needed
md_use_d  in  1  D instr reads/writes HI/LO or starts mult/div
rs_e  in  AW  E-stage source 1
rt_e  in  AW  E-stage source 2
a3_e  in  AW  E-stage destination (0 = no write)
tnew_e  in  TW  E-stage cycles until result ready
md_start_e  in  1  E instr is mult/multu/div/divu
md_div_e  in  1  with md_start_e: 1 = divide, 0 = multiply
rt_m  in  AW  M-stage store-data source
a3_m  in  AW  M-stage destination
tnew_m  in  TW  M-stage cycles until result ready
a3_w  in  AW  W-stage destination (result always ready)
en_pc  out  1  PC write enable
en_d  out  1  F/D register enable
flush_e  out  1  clear D/E register (bubble)
fwd_rs_d  out  2  D rs mux: 0 RF, 1 E, 2 M, 3 W
fwd_rt_d  out  2  D rt mux, same encoding
fwd_rs_e  out  2  E rs mux: 0 pipe, 2 M, 3 W
fwd_rt_e  out  2  E rt mux, same encoding
fwd_rt_m  out  2  M rt mux: 0 pipe, 3 W
md_busy  out  1  HI/LO unit busy
stall_cnt  out  SCW  total stall cycles since reset

Behaviour:
- Address 0 never matches; a3_x = 0 means no write.
- Data-hazard stall: stall_data = 1 if, for src in {rs_d with tuse_rs_d, rt_d with tuse_rt_d}, src != 0 and ((a3_e == src and tnew_e > tuse) or (a3_m == src and tnew_m > tuse)). Combinational.
- MD stall: stall_md = md_use_d & md_busy.
- stall = stall_data | stall_md.
- en_pc = en_d = ~stall; flush_e = stall. All three are combinational, so they are also valid during reset.
- Forward priority is nearest stage first; a stage only forwards when its Tnew is 0:
  - D sources: E (a3_e == src, tnew_e == 0) -> 1; else M (tnew_m == 0) -> 2; else W -> 3; else 0.
  - E sources: M (tnew_m == 0) -> 2; else W -> 3; else 0.
  - fwd_rt_m: W match -> 3; else 0.
- Forwarding outputs are combinational and independent of stall.
- MD counter cnt (CW bits), reset 0:
  - Each clock: if reset, cnt <= 0.
  - Else if md_start_e and cnt == 0, cnt <= (md_div_e ? DIV_LAT : MULT_LAT).
  - Else if cnt != 0, cnt <= cnt - 1.
  - md_start_e while cnt != 0 is ignored; the counter is not reloaded. The MD stall normally prevents this case.
- md_busy = md_start_e | (cnt != 0), combinational.
- Stall counter: stall_cnt resets to 0. Each clock where stall = 1 it increments, saturating at all-ones, with no wrap.
- Reset mid-multiply: cnt and stall_cnt clear on the next edge; md_busy drops unless md_start_e is high.
- Stall and the E-stage md start occur in the same cycle: the start is taken, and flush_e only affects the next E contents.
- A D-stage instruction reading two sources with different hazards stalls if either source requires it.

Test Plan:
- lw $5 in E (a3_e=5, tnew_e=2), beq in D (rs_d=5, tuse=0) -> en_pc=en_d=0, flush_e=1, stall_cnt increments. Next cycle, lw in M (tnew_m=1) still stalls. Following cycle, W match -> fwd_rs_d=3, no stall.
- addu $3 in M (tnew_m=0), addu $3 in W, E rs_e=3 -> fwd_rs_e=2 (M beats W). With rs_e=0 and a3_m=0 -> fwd_rs_e=0.
- ori $8 in E with tnew_e=0, D rt_d=8, tuse=0 -> fwd_rt_d=1, no stall. Same case with tnew_e=1 -> stall=1.
- md_start_e=1, md_div_e=1, DIV_LAT=10 -> md_busy high for 11 cycles (start cycle + 10). mfhi in D during that window -> stall every cycle; no stall once cnt=0.
- Mult start, then reset asserted at cnt=3 -> after the edge, cnt=0, md_busy=0, stall_cnt=0.
- Force stall continuously with SCW=4 -> stall_cnt reaches 15 and holds at 15; sw in M with rt_m=a3_w=9 -> fwd_rt_m=3.

Source files
------------

// File: rtl/hazard_unit.sv
// ============================================================================
//  Module   : hazard_unit
//  Purpose  : Stall/forward control for the 5-stage MIPS pipeline, with a
//             HI/LO busy tracker and a saturating stall-cycle counter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_unit #(
  parameter int AW       = 5,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CW       = 4,
  parameter int SCW      = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [AW-1:0]  rs_d,
  input  logic [AW-1:0]  rt_d,
  input  logic [TW-1:0]  tuse_rs_d,
  input  logic [TW-1:0]  tuse_rt_d,
  input  logic           md_use_d,
  input  logic [AW-1:0]  rs_e,
  input  logic [AW-1:0]  rt_e,
  input  logic [AW-1:0]  a3_e,
  input  logic [TW-1:0]  tnew_e,
  input  logic           md_start_e,
  input  logic           md_div_e,
  input  logic [AW-1:0]  rt_m,
  input  logic [AW-1:0]  a3_m,
  input  logic [TW-1:0]  tnew_m,
  input  logic [AW-1:0]  a3_w,
  output logic           en_pc,
  output logic           en_d,
  output logic           flush_e,
  output logic [1:0]     fwd_rs_d,
  output logic [1:0]     fwd_rt_d,
  output logic [1:0]     fwd_rs_e,
  output logic [1:0]     fwd_rt_e,
  output logic [1:0]     fwd_rt_m,
  output logic           md_busy,
  output logic [SCW-1:0] stall_cnt
);

  localparam logic [CW-1:0] c_mult_lat = CW'(MULT_LAT);
  localparam logic [CW-1:0] c_div_lat  = CW'(DIV_LAT);

  localparam logic [1:0] c_sel_pipe = 2'd0;
  localparam logic [1:0] c_sel_e    = 2'd1;
  localparam logic [1:0] c_sel_m    = 2'd2;
  localparam logic [1:0] c_sel_w    = 2'd3;

  logic [CW-1:0]  r_md_cnt;
  logic [SCW-1:0] r_stall_cnt;
  logic           w_stall_rs;
  logic           w_stall_rt;
  logic           w_stall_md;
  logic           w_stall;

  // A producer blocks a consumer when its result arrives later than needed.
  function automatic logic src_hazard(
    input logic [AW-1:0] src,
    input logic [TW-1:0] tuse,
    input logic [AW-1:0] a3e,
    input logic [TW-1:0] tne,
    input logic [AW-1:0] a3m,
    input logic [TW-1:0] tnm
  );
    return (src != '0) &&
           (((a3e == src) && (tne > tuse)) || ((a3m == src) && (tnm > tuse)));
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic          use_e,
    input logic          use_m,
    input logic [AW-1:0] src,
    input logic [AW-1:0] a3e,
    input logic [TW-1:0] tne,
    input logic [AW-1:0] a3m,
    input logic [TW-1:0] tnm,
    input logic [AW-1:0] a3w
  );
    logic [1:0] sel;
    sel = c_sel_pipe;
    if (src != '0) begin
      if (use_e && (a3e == src) && (tne == '0))
        sel = c_sel_e;
      else if (use_m && (a3m == src) && (tnm == '0))
        sel = c_sel_m;
      else if (a3w == src)
        sel = c_sel_w;
    end
    return sel;
  endfunction

  always_comb begin
    w_stall_rs = src_hazard(rs_d, tuse_rs_d, a3_e, tnew_e, a3_m, tnew_m);
    w_stall_rt = src_hazard(rt_d, tuse_rt_d, a3_e, tnew_e, a3_m, tnew_m);
    w_stall_md = md_use_d & md_busy;
    w_stall    = w_stall_rs | w_stall_rt | w_stall_md;
  end

  assign en_pc   = ~w_stall;
  assign en_d    = ~w_stall;
  assign flush_e = w_stall;

  assign fwd_rs_d = fwd_sel(1'b1, 1'b1, rs_d, a3_e, tnew_e, a3_m, tnew_m, a3_w);
  assign fwd_rt_d = fwd_sel(1'b1, 1'b1, rt_d, a3_e, tnew_e, a3_m, tnew_m, a3_w);
  assign fwd_rs_e = fwd_sel(1'b0, 1'b1, rs_e, a3_e, tnew_e, a3_m, tnew_m, a3_w);
  assign fwd_rt_e = fwd_sel(1'b0, 1'b1, rt_e, a3_e, tnew_e, a3_m, tnew_m, a3_w);
  assign fwd_rt_m = fwd_sel(1'b0, 1'b0, rt_m, a3_e, tnew_e, a3_m, tnew_m, a3_w);

  // A start seen while the unit is still busy is dropped, not reloaded.
  always_ff @(posedge clk) begin
    if (reset)
      r_md_cnt <= '0;
    else if (md_start_e && (r_md_cnt == '0))
      r_md_cnt <= md_div_e ? c_div_lat : c_mult_lat;
    else if (r_md_cnt != '0)
      r_md_cnt <= r_md_cnt - CW'(1);
  end

  assign md_busy = md_start_e | (r_md_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + SCW'(1);
  end

  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, multi-cycle
// sequences and randomized traffic against a cycle-indexed reference model.
`default_nettype none

module tb_hazard_unit;

  logic       clk;
  logic       reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, a3_e, rt_m, a3_m, a3_w;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
  logic       md_use_d, md_start_e, md_div_e;

  logic        en_pc, en_d, flush_e, md_busy;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;
  logic [31:0] stall_cnt;

  logic        s_en_pc, s_en_d, s_flush_e, s_md_busy;
  logic [1:0]  s_fwd_rs_d, s_fwd_rt_d, s_fwd_rs_e, s_fwd_rt_e, s_fwd_rt_m;
  logic [3:0]  s_stall_cnt;

  hazard_unit dut (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .md_use_d(md_use_d),
    .rs_e(rs_e), .rt_e(rt_e), .a3_e(a3_e), .tnew_e(tnew_e),
    .md_start_e(md_start_e), .md_div_e(md_div_e), .rt_m(rt_m), .a3_m(a3_m),
    .tnew_m(tnew_m), .a3_w(a3_w), .en_pc(en_pc), .en_d(en_d), .flush_e(flush_e),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
    .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  hazard_unit #(.SCW(4)) dut4 (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .md_use_d(md_use_d),
    .rs_e(rs_e), .rt_e(rt_e), .a3_e(a3_e), .tnew_e(tnew_e),
    .md_start_e(md_start_e), .md_div_e(md_div_e), .rt_m(rt_m), .a3_m(a3_m),
    .tnew_m(tnew_m), .a3_w(a3_w), .en_pc(s_en_pc), .en_d(s_en_d),
    .flush_e(s_flush_e), .fwd_rs_d(s_fwd_rs_d), .fwd_rt_d(s_fwd_rt_d),
    .fwd_rs_e(s_fwd_rs_e), .fwd_rt_e(s_fwd_rt_e), .fwd_rt_m(s_fwd_rt_m),
    .md_busy(s_md_busy), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
  endtask

  // Reference model: HI/LO is free again at an absolute cycle index.
  longint cyc     = 0;
  longint free_at = 0;
  int     m_scnt  = 0;

  function automatic logic m_busy();
    return md_start_e || (cyc < free_at);
  endfunction

  function automatic logic late(input logic [4:0] s, input logic [1:0] tuse);
    if (s == 0) return 1'b0;
    return (a3_e == s && tnew_e > tuse) || (a3_m == s && tnew_m > tuse);
  endfunction

  function automatic logic exp_stall();
    return late(rs_d, tuse_rs_d) || late(rt_d, tuse_rt_d) || (md_use_d && m_busy());
  endfunction

  // Nearest ready producer wins; first_stage: 1=E, 2=M, 3=W.
  function automatic logic [1:0] exp_fwd(input logic [4:0] s, input int first_stage);
    logic [4:0] dst[1:3];
    logic       rdy[1:3];
    dst[1] = a3_e; rdy[1] = (tnew_e == 0);
    dst[2] = a3_m; rdy[2] = (tnew_m == 0);
    dst[3] = a3_w; rdy[3] = 1'b1;
    if (s == 0) return 2'd0;
    for (int k = first_stage; k <= 3; k++)
      if (dst[k] == s && rdy[k]) return 2'(k);
    return 2'd0;
  endfunction

  always @(posedge clk) begin
    logic st;
    st = exp_stall();
    if (reset) begin
      m_scnt  = 0;
      free_at = cyc + 1;
    end else begin
      if (st) m_scnt++;
      if (md_start_e && cyc >= free_at)
        free_at = cyc + (md_div_e ? 10 : 5) + 1;
    end
    cyc++;
  end

  task automatic check_all(input string tag);
    logic est;
    est = exp_stall();
    chk({tag, ":en_pc"},     en_pc,    !est);
    chk({tag, ":en_d"},      en_d,     !est);
    chk({tag, ":flush_e"},   flush_e,  est);
    chk({tag, ":fwd_rs_d"},  fwd_rs_d, exp_fwd(rs_d, 1));
    chk({tag, ":fwd_rt_d"},  fwd_rt_d, exp_fwd(rt_d, 1));
    chk({tag, ":fwd_rs_e"},  fwd_rs_e, exp_fwd(rs_e, 2));
    chk({tag, ":fwd_rt_e"},  fwd_rt_e, exp_fwd(rt_e, 2));
    chk({tag, ":fwd_rt_m"},  fwd_rt_m, exp_fwd(rt_m, 3));
    chk({tag, ":md_busy"},   md_busy,  m_busy());
    chk({tag, ":stall_cnt"}, stall_cnt, m_scnt);
    chk({tag, ":s4_cnt"},    s_stall_cnt, (m_scnt > 15) ? 15 : m_scnt);
    chk({tag, ":s4_ctl"},    {s_en_pc, s_en_d, s_flush_e, s_md_busy},
                             {!est, !est, est, m_busy()});
    chk({tag, ":s4_fwd"},    {s_fwd_rs_d, s_fwd_rt_d, s_fwd_rs_e, s_fwd_rt_e, s_fwd_rt_m},
                             {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m});
  endtask

  // Inputs change right after negedge; check mid-phase, then move on.
  task automatic step(input string tag);
    #2;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs_d = 0; rt_d = 0; tuse_rs_d = 3; tuse_rt_d = 3; md_use_d = 0;
    rs_e = 0; rt_e = 0; a3_e = 0; tnew_e = 0; md_start_e = 0; md_div_e = 0;
    rt_m = 0; a3_m = 0; tnew_m = 0; a3_w = 0;
  endtask

  typedef struct {
    logic [4:0] rs_d, rt_d;
    logic [1:0] tu_rs, tu_rt;
    logic [4:0] rs_e, rt_e, a3_e;
    logic [1:0] tn_e;
    logic [4:0] rt_m, a3_m;
    logic [1:0] tn_m;
    logic [4:0] a3_w;
    logic       st;
    logic [1:0] f_rsd, f_rtd, f_rse, f_rte, f_rtm;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int busy_n;
    tbl[0]  = '{5, 0, 0, 3,  0, 0, 5, 2,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0};
    tbl[1]  = '{5, 0, 0, 3,  0, 0, 0, 0,  0, 5, 1, 0,  1, 0, 0, 0, 0, 0};
    tbl[2]  = '{5, 0, 0, 3,  0, 0, 0, 0,  0, 0, 0, 5,  0, 3, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 3, 3,  3, 0, 0, 0,  0, 3, 0, 3,  0, 0, 0, 2, 0, 0};
    tbl[4]  = '{0, 0, 3, 3,  0, 0, 0, 0,  0, 0, 0, 3,  0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 8, 3, 0,  0, 0, 8, 0,  0, 0, 0, 0,  0, 0, 1, 0, 0, 0};
    tbl[6]  = '{0, 8, 3, 0,  0, 0, 8, 1,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0};
    tbl[7]  = '{4, 6, 1, 0,  0, 0, 4, 1,  0, 6, 1, 0,  1, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 3, 3,  0, 9, 0, 0,  9, 0, 0, 9,  0, 0, 0, 0, 3, 3};
    tbl[9]  = '{0, 0, 0, 0,  0, 0, 0, 3,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 7, 3, 2,  0, 7, 0, 0,  0, 7, 1, 7,  0, 0, 3, 0, 3, 0};
    tbl[11] = '{2, 0, 0, 3,  2, 0, 0, 0,  0, 2, 0, 2,  0, 2, 0, 2, 0, 0};
    tbl[12] = '{1, 0, 0, 3,  1, 0, 1, 0,  0, 1, 0, 0,  0, 1, 0, 2, 0, 0};

    idle_inputs();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    #2;
    chk("reset:stall_cnt", stall_cnt, 0);
    chk("reset:md_busy", md_busy, 0);
    chk("reset:en_pc", en_pc, 1);
    @(negedge clk);

    // Directed single-cycle vectors.
    foreach (tbl[i]) begin
      rs_d = tbl[i].rs_d; rt_d = tbl[i].rt_d;
      tuse_rs_d = tbl[i].tu_rs; tuse_rt_d = tbl[i].tu_rt;
      rs_e = tbl[i].rs_e; rt_e = tbl[i].rt_e; a3_e = tbl[i].a3_e; tnew_e = tbl[i].tn_e;
      rt_m = tbl[i].rt_m; a3_m = tbl[i].a3_m; tnew_m = tbl[i].tn_m; a3_w = tbl[i].a3_w;
      #2;
      chk($sformatf("vec%0d:flush_e", i), flush_e, tbl[i].st);
      chk($sformatf("vec%0d:en_pc", i), en_pc, !tbl[i].st);
      chk($sformatf("vec%0d:fwd", i),
          {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m},
          {tbl[i].f_rsd, tbl[i].f_rtd, tbl[i].f_rse, tbl[i].f_rte, tbl[i].f_rtm});
      check_all($sformatf("vec%0d", i));
      @(negedge clk);
    end
    idle_inputs();
    step("idle");

    // Divide: busy for the start cycle plus DIV_LAT, mfhi stalls throughout.
    md_start_e = 1; md_div_e = 1; md_use_d = 1;
    busy_n = 0;
    for (int i = 0; i < 14; i++) begin
      #2;
      if (md_busy) busy_n++;
      chk($sformatf("div%0d:stall", i), flush_e, (i <= 10));
      check_all("div");
      @(negedge clk);
      md_start_e = 0;
    end
    chk("div:busy_len", busy_n, 11);

    // Multiply aborted by reset while the counter holds 3.
    md_start_e = 1; md_div_e = 0; md_use_d = 1;
    step("mul0");
    md_start_e = 0;
    step("mul5");
    step("mul4");
    reset = 1;
    step("mul3");
    reset = 0; md_use_d = 0;
    #2;
    chk("mulrst:md_busy", md_busy, 0);
    chk("mulrst:stall_cnt", stall_cnt, 0);
    chk("mulrst:s4_cnt", s_stall_cnt, 0);
    @(negedge clk);

    // Continuous load-use stall saturates the narrow counter.
    a3_e = 5; tnew_e = 2; rs_d = 5; tuse_rs_d = 0;
    for (int i = 0; i < 20; i++) step("sat");
    idle_inputs();
    #2;
    chk("sat:s4_cnt", s_stall_cnt, 15);
    chk("sat:stall_cnt", stall_cnt, 20);
    @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      a3_e = 5'($urandom_range(0, 3)); a3_m = 5'($urandom_range(0, 3));
      a3_w = 5'($urandom_range(0, 3)); rt_m = 5'($urandom_range(0, 3));
      tuse_rs_d = 2'($urandom_range(0, 3)); tuse_rt_d = 2'($urandom_range(0, 3));
      tnew_e = 2'($urandom_range(0, 3)); tnew_m = 2'($urandom_range(0, 3));
      md_use_d = 1'($urandom_range(0, 1));
      md_start_e = ($urandom_range(0, 7) == 0);
      md_div_e = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 63) == 0);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
